abc_vec_sched: RTL and testbench
================================

Name: abc_vec_sched

Overview:
- Round-robin scheduler that shares one packed-vector builder between NREQ word-wide requesters.
- Each cycle in FILL it grants at most one requester and writes that word into the next lane of an No1-lane buffer (logic [No1-1:0][W-1:0]).
- When all lanes are written, it presents the full vector to the downstream abc consumer over a valid/ready handshake.
- Sits in front of Abc-style blocks that take an `abc` packed-array input.

Parameters:
- No1, 6, number of lanes in the output vector; legal range 1..64.
- NREQ, 4, number of requesters; legal range 1..16.
- W, 32, lane width in bits.

Ports:
- ck  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  [NREQ-1:0][W-1:0]  per-requester word.
- req_ready  output  NREQ  one-hot grant; the word is accepted when req_valid[i] & req_ready[i].
- out_valid  output  1  full vector available.
- out_ready  input  1  consumer accepts the vector.
- out_abc  output  [No1-1:0][W-1:0]  assembled vector; lane 0 is the first word written.
- out_src  output  [No1-1:0][$clog2(NREQ>1?NREQ:2)-1:0]  requester index that supplied each lane.
- lane_cnt  output  $clog2(No1+1)  lanes written so far in the current vector.

Behaviour:
- Asynchronous reset, effective immediately when rst rises:
  - state=FILL, lane_cnt=0, out_valid=0, out_abc=0, out_src=0.
  - Round-robin pointer rr=0.
  - req_ready is forced to 0 while rst is high.
- States:
  - FILL: build the vector. out_valid=0.
  - SEND: out_valid=1. req_ready=0. out_abc and out_src are held stable.
- Arbitration in FILL:
  - req_ready is combinational from req_valid and rr.
  - Grant goes to the first asserted req_valid searching upward from index rr, wrapping NREQ-1 to 0.
  - No req_valid asserted gives req_ready=0 and no state change.
  - req_ready never asserts for a requester with req_valid=0.
- Accept (grant g this cycle):
  - out_abc[lane_cnt] <= req_data[g]; out_src[lane_cnt] <= g.
  - lane_cnt <= lane_cnt+1; rr <= (g+1) mod NREQ.
- FILL to SEND:
  - Taken on the accept that writes lane No1-1; lane_cnt becomes No1 in the same edge.
  - out_valid rises the cycle after the last accept (1-cycle latency).
  - With No1=1, every accepted word moves straight to SEND.
- SEND to FILL:
  - Taken on out_valid & out_ready: lane_cnt <= 0; out_abc is retained (not cleared).
  - The next grant can occur on the first FILL cycle, so throughput is 1 vector per No1+1 cycles at best.
  - No bypass: no grant in the same cycle as the vector handshake.
- Backpressure: out_ready low in SEND holds indefinitely with all outputs stable; requesters see req_ready=0.
- Fairness: any requester holding req_valid is granted within NREQ accepts.
- Reset mid-operation (FILL or SEND): partial or pending vector discarded, rr returns to 0.
- Widths:
  - Lane index and rr arithmetic wrap explicitly at No1 and NREQ, not at the power of two.
  - Never index out_abc with lane_cnt==No1.
- No combinational path from out_ready to req_ready within one cycle.

Optional Feature:
- Macro: ABC_VEC_SCHED_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 in FILL with lane_cnt>0: zero-fill lanes lane_cnt..No1-1 and set their out_src to 0.
  - The vector enters SEND next cycle; lane_cnt reports the real word count, not No1.
  - A grant coinciding with flush is accepted first, then the remaining lanes are padded.
  - flush with lane_cnt==0 and no grant, or flush in SEND, is ignored.
- Undefined: no flush port; a vector is only emitted when full.

Test Plan:
- Reset: rst pulse mid-FILL at lane_cnt=3 -> lane_cnt=0, out_valid=0, rr=0 asynchronously, before the next ck edge.
- Single requester: No1=6; req 2 valid, data 0x10..0x15 on consecutive cycles, out_ready=1:
  - req_ready=4'b0100 for 6 cycles, then out_valid=1 for 1 cycle.
  - out_abc=[0x15,0x14,0x13,0x12,0x11,0x10] (lane 5 first); out_src all 2.
- Round-robin: all 4 req_valid held high -> grant order 0,1,2,3,0,1; out_src=[1,0,3,2,1,0] (lane 5 first); next vector starts with grant 2.
- Backpressure: out_ready=0 for 10 cycles in SEND:
  - out_valid stays 1, out_abc stable, req_ready=0.
  - On out_ready=1, FILL is re-entered next cycle and lane_cnt=0.
- Sparse requests: req 3 then req 1, 1 idle cycle between each, No1=2 -> lane0=req3 data, lane1=req1 data; rr=2 after.
- Flush (ABC_VEC_SCHED_FLUSH_EN): 2 words (0xA, 0xB) then flush=1 -> out_abc lanes 2..5 = 0, lane_cnt=2, out_valid next cycle.

Source files
------------

// File: rtl/abc_vec_sched_if.sv
// Requester / consumer bundle for abc_vec_sched. The slave modport is the scheduler side,
// and the master modport is the requester/consumer side.
interface abc_vec_sched_if #(
    parameter int No1  = 6,
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int SW  = $clog2(NREQ > 1 ? NREQ : 2);
    localparam int LCW = $clog2(No1 + 1);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][W-1:0]  req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [No1-1:0][W-1:0]   out_abc;
    logic [No1-1:0][SW-1:0]  out_src;
    logic [LCW-1:0]          lane_cnt;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_abc, out_src, lane_cnt
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_abc, out_src, lane_cnt
    );
endinterface

// File: rtl/abc_vec_sched.sv
// Round-robin scheduler that packs words from NREQ requesters into an No1-lane abc vector.
// The optional early flush with zero padding is enabled by ABC_VEC_SCHED_FLUSH_EN.
module abc_vec_sched #(
    parameter int No1  = 6,
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic ck,
    input  logic rst,
`ifdef ABC_VEC_SCHED_FLUSH_EN
    input  logic flush,
`endif
    abc_vec_sched_if.slave bus
);
    localparam int SW  = $clog2(NREQ > 1 ? NREQ : 2);
    localparam int LCW = $clog2(No1 + 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]             state_reg, state_next;
    logic [LCW-1:0]         lane_cnt_reg, lane_cnt_next;
    logic [SW-1:0]          rr_reg, rr_next;
    logic [No1-1:0][W-1:0]  abc_reg;
    logic [No1-1:0][SW-1:0] src_reg;

    logic [NREQ-1:0] grant_oh;
    logic [SW-1:0]   grant_idx;
    logic            grant_any;
    logic [W-1:0]    grant_data;
    logic [SW:0]     cand_sum;
    logic [SW-1:0]   cand;
    logic            accept;
    logic            last_lane;
    logic            flush_fire;
    logic [No1-1:0]  wr_lane;
    logic [No1-1:0]  pad_lane;

    // Search upward from rr with an explicit wrap at NREQ. The grant is suppressed
    // outside FILL and while reset is held.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        if (state_reg == FILL && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                cand_sum = {1'b0, rr_reg} + (SW+1)'(k);
                if (cand_sum >= (SW+1)'(NREQ)) begin
                    cand_sum = cand_sum - (SW+1)'(NREQ);
                end
                cand = cand_sum[SW-1:0];
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) begin
                grant_oh[grant_idx] = 1'b1;
            end
        end
    end

    assign grant_data = bus.req_data[grant_idx];
    assign accept     = grant_any;
    assign last_lane  = (lane_cnt_reg == LCW'(No1 - 1));

`ifdef ABC_VEC_SCHED_FLUSH_EN
    assign flush_fire = (state_reg == FILL) && flush && (accept || lane_cnt_reg != '0);
`else
    assign flush_fire = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        lane_cnt_next = lane_cnt_reg;
        rr_next       = rr_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    lane_cnt_next = lane_cnt_reg + 1'b1;
                    rr_next       = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                if ((accept && last_lane) || flush_fire) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                // There is no bypass: the handshake cycle never grants, so FILL restarts empty.
                if (bus.out_ready) begin
                    state_next    = FILL;
                    lane_cnt_next = '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_reg    <= FILL;
            lane_cnt_reg <= '0;
            rr_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            lane_cnt_reg <= lane_cnt_next;
            rr_reg       <= rr_next;
        end
    end

    // Each lane compares against its own constant index, so a full count never addresses a lane.
    genvar gi;
    generate
        for (gi = 0; gi < No1; gi++) begin : g_lane
            assign wr_lane[gi]  = accept && (lane_cnt_reg == LCW'(gi));
            assign pad_lane[gi] = flush_fire && (LCW'(gi) >= lane_cnt_next);

            always_ff @(posedge ck or posedge rst) begin
                if (rst) begin
                    abc_reg[gi] <= '0;
                    src_reg[gi] <= '0;
                end else if (wr_lane[gi]) begin
                    abc_reg[gi] <= grant_data;
                    src_reg[gi] <= grant_idx;
                end else if (pad_lane[gi]) begin
                    abc_reg[gi] <= '0;
                    src_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    assign bus.req_ready = grant_oh;
    assign bus.out_valid = (state_reg == SEND);
    assign bus.out_abc   = abc_reg;
    assign bus.out_src   = src_reg;
    assign bus.lane_cnt  = lane_cnt_reg;
endmodule

// File: tb/tb_abc_vec_sched.sv
// Directed bench for abc_vec_sched. It uses a 6-lane instance and a 2-lane instance,
// both with 4 requesters. The flush scenario runs when ABC_VEC_SCHED_FLUSH_EN is defined.
module tb_abc_vec_sched;
    logic ck;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    abc_vec_sched_if #(.No1(6), .NREQ(4), .W(32)) b1 ();
    abc_vec_sched_if #(.No1(2), .NREQ(4), .W(32)) b2 ();

    abc_vec_sched #(.No1(6), .NREQ(4), .W(32)) u1 (
        .ck    (ck),
        .rst   (rst),
`ifdef ABC_VEC_SCHED_FLUSH_EN
        .flush (flush),
`endif
        .bus   (b1.slave)
    );

    abc_vec_sched #(.No1(2), .NREQ(4), .W(32)) u2 (
        .ck    (ck),
        .rst   (rst),
`ifdef ABC_VEC_SCHED_FLUSH_EN
        .flush (1'b0),
`endif
        .bus   (b2.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        b1.req_valid = 4'hF;
        #1;
        checks++; if (b1.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", b1.req_ready); end
        checks++; if (b1.lane_cnt !== 3'd0) begin failures++; $display("FAIL reset_lane_cnt got=%0d exp=0", b1.lane_cnt); end
        checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b1.out_valid); end
        checks++; if (b1.out_abc !== '0) begin failures++; $display("FAIL reset_out_abc got=%0h exp=0", b1.out_abc); end
        tick();
        rst = 1'b0;
        b1.req_valid = 4'b0100;
        b1.req_data[2] = 32'h55;
        repeat (3) tick();
        checks++; if (b1.lane_cnt !== 3'd3) begin failures++; $display("FAIL prefill_lane_cnt got=%0d exp=3", b1.lane_cnt); end
        #2 rst = 1'b1;
        #1;
        $display("reset mid-FILL: lane_cnt=%0d out_valid=%b", b1.lane_cnt, b1.out_valid);
        checks++; if (b1.lane_cnt !== 3'd0) begin failures++; $display("FAIL async_lane_cnt got=%0d exp=0", b1.lane_cnt); end
        checks++; if (b1.req_ready !== 4'b0000) begin failures++; $display("FAIL async_ready got=%b exp=0000", b1.req_ready); end
        tick();
        rst = 1'b0;
        b1.req_valid = 4'hF;
        #1;
        checks++; if (b1.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_rr got=%b exp=0001", b1.req_ready); end
        b1.req_valid = 4'h0;
    endtask

    task automatic test_single();
        logic [5:0][31:0] e_abc;
        logic [5:0][1:0]  e_src;
        b1.out_ready = 1'b1;
        b1.req_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            b1.req_data[2] = 32'h10 + 32'(i);
            e_abc[i] = 32'h10 + 32'(i);
            e_src[i] = 2'd2;
            #1;
            $display("single word %0d: ready=%b lane_cnt=%0d", i, b1.req_ready, b1.lane_cnt);
            checks++; if (b1.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready%0d got=%b exp=0100", i, b1.req_ready); end
            checks++; if (b1.lane_cnt !== 3'(i)) begin failures++; $display("FAIL single_lane_cnt%0d got=%0d exp=%0d", i, b1.lane_cnt, i); end
            tick();
        end
        b1.req_valid = 4'h0;
        #1;
        checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", b1.out_valid); end
        checks++; if (b1.lane_cnt !== 3'd6) begin failures++; $display("FAIL single_full_cnt got=%0d exp=6", b1.lane_cnt); end
        checks++; if (b1.req_ready !== 4'b0000) begin failures++; $display("FAIL single_send_ready got=%b exp=0000", b1.req_ready); end
        checks++; if (b1.out_abc !== e_abc) begin failures++; $display("FAIL single_abc got=%0h exp=%0h", b1.out_abc, e_abc); end
        checks++; if (b1.out_src !== e_src) begin failures++; $display("FAIL single_src got=%0h exp=%0h", b1.out_src, e_src); end
        tick();
        checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", b1.out_valid); end
        checks++; if (b1.lane_cnt !== 3'd0) begin failures++; $display("FAIL single_cnt_clear got=%0d exp=0", b1.lane_cnt); end
    endtask

    task automatic test_round_robin();
        logic [5:0][31:0] e_abc;
        logic [5:0][1:0]  e_src;
        rst = 1'b1;
        #1 rst = 1'b0;
        b1.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) b1.req_data[j] = 32'hA0 + 32'(j);
        b1.req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            e_src[i] = 2'(i % 4);
            e_abc[i] = 32'hA0 + 32'(i % 4);
            #1;
            $display("rr accept %0d: ready=%b", i, b1.req_ready);
            checks++; if (b1.req_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, b1.req_ready, 4'(1 << (i % 4))); end
            tick();
        end
        checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid got=%b exp=1", b1.out_valid); end
        checks++; if (b1.out_src !== e_src) begin failures++; $display("FAIL rr_src got=%0h exp=%0h", b1.out_src, e_src); end
        checks++; if (b1.out_abc !== e_abc) begin failures++; $display("FAIL rr_abc got=%0h exp=%0h", b1.out_abc, e_abc); end
    endtask

    task automatic test_backpressure();
        logic [5:0][31:0] e_abc;
        for (int i = 0; i < 6; i++) e_abc[i] = 32'hA0 + 32'(i % 4);
        for (int c = 0; c < 10; c++) begin
            $display("backpressure cycle %0d: valid=%b ready=%b", c, b1.out_valid, b1.req_ready);
            checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", c, b1.out_valid); end
            checks++; if (b1.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", c, b1.req_ready); end
            checks++; if (b1.out_abc !== e_abc) begin failures++; $display("FAIL bp_abc%0d got=%0h exp=%0h", c, b1.out_abc, e_abc); end
            tick();
        end
        b1.out_ready = 1'b1;
        tick();
        checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", b1.out_valid); end
        checks++; if (b1.lane_cnt !== 3'd0) begin failures++; $display("FAIL bp_release_cnt got=%0d exp=0", b1.lane_cnt); end
        checks++; if (b1.req_ready !== 4'b0100) begin failures++; $display("FAIL bp_next_grant got=%b exp=0100", b1.req_ready); end
        b1.req_valid = 4'h0;
    endtask

    task automatic test_sparse();
        logic [1:0][31:0] e_abc;
        logic [1:0][1:0]  e_src;
        e_abc[0] = 32'h33; e_abc[1] = 32'h11;
        e_src[0] = 2'd3;   e_src[1] = 2'd1;
        b2.out_ready = 1'b0;
        b2.req_valid = 4'b1000;
        b2.req_data[3] = 32'h33;
        #1;
        checks++; if (b2.req_ready !== 4'b1000) begin failures++; $display("FAIL sparse_grant3 got=%b exp=1000", b2.req_ready); end
        tick();
        b2.req_valid = 4'h0;
        #1;
        checks++; if (b2.lane_cnt !== 2'd1) begin failures++; $display("FAIL sparse_idle_cnt got=%0d exp=1", b2.lane_cnt); end
        checks++; if (b2.req_ready !== 4'b0000) begin failures++; $display("FAIL sparse_idle_ready got=%b exp=0000", b2.req_ready); end
        tick();
        b2.req_valid = 4'b0010;
        b2.req_data[1] = 32'h11;
        #1;
        checks++; if (b2.req_ready !== 4'b0010) begin failures++; $display("FAIL sparse_grant1 got=%b exp=0010", b2.req_ready); end
        tick();
        b2.req_valid = 4'h0;
        #1;
        $display("sparse vector: valid=%b abc=%0h src=%0h", b2.out_valid, b2.out_abc, b2.out_src);
        checks++; if (b2.out_valid !== 1'b1) begin failures++; $display("FAIL sparse_valid got=%b exp=1", b2.out_valid); end
        checks++; if (b2.out_abc !== e_abc) begin failures++; $display("FAIL sparse_abc got=%0h exp=%0h", b2.out_abc, e_abc); end
        checks++; if (b2.out_src !== e_src) begin failures++; $display("FAIL sparse_src got=%0h exp=%0h", b2.out_src, e_src); end
        b2.out_ready = 1'b1;
        tick();
        b2.out_ready = 1'b0;
        b2.req_valid = 4'hF;
        #1;
        checks++; if (b2.req_ready !== 4'b0100) begin failures++; $display("FAIL sparse_rr got=%b exp=0100", b2.req_ready); end
        b2.req_valid = 4'h0;
    endtask

`ifdef ABC_VEC_SCHED_FLUSH_EN
    task automatic test_flush();
        logic [5:0][31:0] e_abc;
        logic [5:0][1:0]  e_src;
        e_abc = '0; e_src = '0;
        e_abc[0] = 32'hA; e_abc[1] = 32'hB;
        e_src[0] = 2'd2;  e_src[1] = 2'd2;
        b1.out_ready = 1'b0;
        b1.req_valid = 4'b0100;
        b1.req_data[2] = 32'hA;
        tick();
        b1.req_data[2] = 32'hB;
        tick();
        b1.req_valid = 4'h0;
        flush = 1'b1;
        #1;
        checks++; if (b1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_pre_valid got=%b exp=0", b1.out_valid); end
        tick();
        flush = 1'b0;
        $display("flush vector: valid=%b lane_cnt=%0d abc=%0h", b1.out_valid, b1.lane_cnt, b1.out_abc);
        checks++; if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", b1.out_valid); end
        checks++; if (b1.lane_cnt !== 3'd2) begin failures++; $display("FAIL flush_cnt got=%0d exp=2", b1.lane_cnt); end
        checks++; if (b1.out_abc !== e_abc) begin failures++; $display("FAIL flush_abc got=%0h exp=%0h", b1.out_abc, e_abc); end
        checks++; if (b1.out_src !== e_src) begin failures++; $display("FAIL flush_src got=%0h exp=%0h", b1.out_src, e_src); end
        b1.out_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        b1.req_valid = '0; b1.req_data = '0; b1.out_ready = 1'b0;
        b2.req_valid = '0; b2.req_data = '0; b2.out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sparse();
`ifdef ABC_VEC_SCHED_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
